// File: rtl/esl_clk_check_pkg.sv
// Shared types and helpers for the multi-channel clock-check controller.
//   ctrl_state_e  : FSM state, encoding visible on control_fsm_state
//   FAIL_CNT_W    : width of each per-channel consecutive-failure counter
//   ch_width()    : channel-select width for a given channel count
//   clamp_window(): maps a zero test window onto a one-cycle window
package esl_clk_check_pkg;

    typedef enum logic [2:0] {
        ST_RESET           = 3'b000,
        ST_COUNT_ACK       = 3'b001,
        ST_COUNTING        = 3'b010,
        ST_NEXT_CH         = 3'b011,
        ST_FLAG_GEN        = 3'b100,
        ST_UNEXP_ERROR     = 3'b101,
        ST_CUT_CLK_STOPPED = 3'b110
    } ctrl_state_e;

    // Enough for a failure limit of up to 7.
    localparam int FAIL_CNT_W = 3;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Valid for timer widths up to 32 bits.
    function automatic logic [31:0] clamp_window(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/esl_clk_check_fsm_mc_if.sv
// Bundle between the clock-check controller and its surroundings.
//   slave  : controller side (takes enable/window/acks, drives selects/flags)
//   master : environment side (per-channel cut counters, flag gen, CSRs)
interface esl_clk_check_fsm_mc_if #(
    parameter int N_CH     = 4,
    parameter int TC_WIDTH = 16
) ();
    import esl_clk_check_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic                enable;
    logic [TC_WIDTH-1:0] test_window;
    logic [N_CH-1:0]     reset_ack;
    logic [N_CH-1:0]     cut_count_available;
    logic                flag_int_error;
    logic [CH_W-1:0]     ch_sel;
    logic [N_CH-1:0]     reset_cut_count;
    logic [N_CH-1:0]     en_cut_count;
    logic                en_flag_gen;
    logic                cut_clock_stopped;
    logic [N_CH-1:0]     stopped_sticky;
    logic [2:0]          control_fsm_state;

    modport slave (
        input  enable, test_window, reset_ack, cut_count_available, flag_int_error,
        output ch_sel, reset_cut_count, en_cut_count, en_flag_gen,
               cut_clock_stopped, stopped_sticky, control_fsm_state
    );

    modport master (
        output enable, test_window, reset_ack, cut_count_available, flag_int_error,
        input  ch_sel, reset_cut_count, en_cut_count, en_flag_gen,
               cut_clock_stopped, stopped_sticky, control_fsm_state
    );

endinterface

// File: rtl/esl_ref_timer.sv
// Saturating reference-clock timer with a terminal-count compare.
//   clk, rst  : reference clock, async active-high reset
//   clear_i   : restart from zero on the next edge (wins over enable_i)
//   enable_i  : count up by one per cycle, holding at all-ones
//   limit_i   : window length in cycles (one bit wider than the counter)
//   tc_o      : high while the counter sits on limit_i - 1
module esl_ref_timer #(
    parameter int TC_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [TC_WIDTH:0] limit_i,
    output logic              tc_o
);

    logic [TC_WIDTH-1:0] count_q, count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + TC_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compare at full width so a limit of 2^TC_WIDTH is reachable.
    assign tc_o = ({1'b0, count_q} == (limit_i - (TC_WIDTH + 1)'(1)));

endmodule

// File: rtl/esl_clk_check_fsm_mc.sv
// Round-robin clock-check controller: one reference-timer engine shared over
// N_CH clock-under-test counters, with a per-channel consecutive-failure
// filter before a channel is declared stopped.
//   ref_clk, ref_rst : reference clock, async active-high reset
//   bus (slave)      : enable/test_window/acks in; channel select, one-hot
//                      counter reset/enable, flag pulses, sticky status and
//                      state encoding out (all registered)
module esl_clk_check_fsm_mc #(
    parameter int N_CH        = 4,
    parameter int TC_WIDTH    = 16,
    parameter int ACK_TIMEOUT = 256,
    parameter int FAIL_LIMIT  = 2
) (
    input  logic                 ref_clk,
    input  logic                 ref_rst,
    esl_clk_check_fsm_mc_if.slave bus
);
    import esl_clk_check_pkg::*;

    localparam int                    CH_W      = ch_width(N_CH);
    localparam logic [TC_WIDTH:0]     ACK_LIMIT = (TC_WIDTH + 1)'(ACK_TIMEOUT);
    localparam logic [FAIL_CNT_W-1:0] FAIL_LIM  = FAIL_CNT_W'(FAIL_LIMIT);

    ctrl_state_e           state_q, state_d;
    logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
    logic [FAIL_CNT_W-1:0] fail_cnt_q [N_CH];
    logic [FAIL_CNT_W-1:0] fail_next;
    logic                  fail_inc, fail_clr;
    logic [TC_WIDTH-1:0]   window_q, window_d;
    logic [TC_WIDTH:0]     limit;
    logic                  tc;

    logic [N_CH-1:0] sel_oh_d;
    logic [N_CH-1:0] reset_cut_q, reset_cut_d;
    logic [N_CH-1:0] en_cut_q, en_cut_d;
    logic [N_CH-1:0] sticky_q, sticky_d;
    logic            en_flag_gen_q, en_flag_gen_d;
    logic            cut_stopped_q, cut_stopped_d;

    // The timer restarts on every state change; the window length is only
    // meaningful while counting, otherwise the handshake timeout applies.
    assign limit = (state_q == ST_COUNTING) ? {1'b0, window_q} : ACK_LIMIT;

    esl_ref_timer #(
        .TC_WIDTH (TC_WIDTH)
    ) u_timer (
        .clk      (ref_clk),
        .rst      (ref_rst),
        .clear_i  (state_d != state_q),
        .enable_i (state_q != ST_UNEXP_ERROR),
        .limit_i  (limit),
        .tc_o     (tc)
    );

    // Next state, channel pointer and fail-counter update requests.
    always_comb begin
        state_d   = state_q;
        ch_sel_d  = ch_sel_q;
        fail_inc  = 1'b0;
        fail_clr  = 1'b0;
        fail_next = fail_cnt_q[ch_sel_q] + FAIL_CNT_W'(1);

        unique case (state_q)
            ST_RESET: begin
                if (bus.enable) state_d = ST_COUNT_ACK;
            end
            ST_COUNT_ACK: begin
                if (bus.reset_ack[ch_sel_q]) begin
                    state_d = ST_COUNTING;
                end else if (tc) begin
                    fail_inc = 1'b1;
                    state_d  = (fail_next < FAIL_LIM) ? ST_RESET : ST_CUT_CLK_STOPPED;
                end
            end
            ST_COUNTING: begin
                if (tc) state_d = ST_FLAG_GEN;
            end
            ST_FLAG_GEN: begin
                if (bus.cut_count_available[ch_sel_q]) begin
                    fail_clr = 1'b1;
                    state_d  = ST_NEXT_CH;
                end else if (tc) begin
                    fail_inc = 1'b1;
                    state_d  = (fail_next < FAIL_LIM) ? ST_RESET : ST_CUT_CLK_STOPPED;
                end
            end
            ST_CUT_CLK_STOPPED: begin
                fail_clr = 1'b1;
                state_d  = ST_NEXT_CH;
            end
            ST_NEXT_CH: begin
                ch_sel_d = (ch_sel_q == CH_W'(N_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
                state_d  = ST_RESET;
            end
            ST_UNEXP_ERROR: begin
                state_d = ST_UNEXP_ERROR;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // An internal error pre-empts every other transition and side effect.
        if (bus.flag_int_error) begin
            state_d  = ST_UNEXP_ERROR;
            ch_sel_d = ch_sel_q;
            fail_inc = 1'b0;
            fail_clr = 1'b0;
        end
    end

    always_comb begin
        sel_oh_d           = '0;
        sel_oh_d[ch_sel_d] = 1'b1;
    end

    // Outputs are decoded from the upcoming state and registered, so each
    // output lines up with the state it belongs to.
    always_comb begin
        reset_cut_d   = ((state_d == ST_RESET) || (state_d == ST_COUNT_ACK)) ? sel_oh_d : '0;
        en_cut_d      = (state_d == ST_COUNTING) ? sel_oh_d : '0;
        en_flag_gen_d = ((state_q == ST_FLAG_GEN) && (state_d == ST_NEXT_CH)) ||
                        (state_d == ST_CUT_CLK_STOPPED);
        cut_stopped_d = (state_d == ST_CUT_CLK_STOPPED);
        sticky_d      = sticky_q | ((state_d == ST_CUT_CLK_STOPPED) ? sel_oh_d : '0);
        // Window is frozen on entry to COUNTING; later edits wait for the next one.
        window_d      = ((state_d == ST_COUNTING) && (state_q != ST_COUNTING)) ?
                        TC_WIDTH'(clamp_window(32'(bus.test_window))) : window_q;
    end

    always_ff @(posedge ref_clk or posedge ref_rst) begin
        if (ref_rst) begin
            state_q       <= ST_RESET;
            ch_sel_q      <= '0;
            window_q      <= TC_WIDTH'(1);
            reset_cut_q   <= '0;
            en_cut_q      <= '0;
            sticky_q      <= '0;
            en_flag_gen_q <= 1'b0;
            cut_stopped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_sel_q      <= ch_sel_d;
            window_q      <= window_d;
            reset_cut_q   <= reset_cut_d;
            en_cut_q      <= en_cut_d;
            sticky_q      <= sticky_d;
            en_flag_gen_q <= en_flag_gen_d;
            cut_stopped_q <= cut_stopped_d;
        end
    end

    // NOTE: this small counter array is reset explicitly; a leftover count
    // after reset would shorten the failure filter on the first round.
    always_ff @(posedge ref_clk or posedge ref_rst) begin
        if (ref_rst) begin
            for (int i = 0; i < N_CH; i++) fail_cnt_q[i] <= '0;
        end else if (fail_clr) begin
            fail_cnt_q[ch_sel_q] <= '0;
        end else if (fail_inc) begin
            fail_cnt_q[ch_sel_q] <= fail_next;
        end
    end

    assign bus.ch_sel            = ch_sel_q;
    assign bus.reset_cut_count   = reset_cut_q;
    assign bus.en_cut_count      = en_cut_q;
    assign bus.en_flag_gen       = en_flag_gen_q;
    assign bus.cut_clock_stopped = cut_stopped_q;
    assign bus.stopped_sticky    = sticky_q;
    assign bus.control_fsm_state = state_q;

endmodule

// File: tb/tb_esl_clk_check_fsm_mc.sv
// Directed bench for esl_clk_check_fsm_mc: round-robin sequencing, window
// length, ack/available timeouts, failure filter, priorities, error lock-up
// and asynchronous reset.
module tb_esl_clk_check_fsm_mc;

    localparam int N_CH        = 4;
    localparam int TC_WIDTH    = 16;
    localparam int ACK_TIMEOUT = 256;
    localparam int FAIL_LIMIT  = 2;

    localparam logic [31:0] S_RESET   = 32'h0;
    localparam logic [31:0] S_ACK     = 32'h1;
    localparam logic [31:0] S_COUNT   = 32'h2;
    localparam logic [31:0] S_NEXT    = 32'h3;
    localparam logic [31:0] S_FLAG    = 32'h4;
    localparam logic [31:0] S_ERR     = 32'h5;
    localparam logic [31:0] S_STOPPED = 32'h6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    esl_clk_check_fsm_mc_if #(.N_CH(N_CH), .TC_WIDTH(TC_WIDTH)) bus ();

    esl_clk_check_fsm_mc #(
        .N_CH        (N_CH),
        .TC_WIDTH    (TC_WIDTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .FAIL_LIMIT  (FAIL_LIMIT)
    ) dut (
        .ref_clk (clk),
        .ref_rst (rst),
        .bus     (bus)
    );

    int tests       = 0;
    int failed      = 0;
    int flag_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    // Advance one edge and sample 1 ns later; counts flag pulses seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.en_flag_gen === 1'b1) flag_pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input logic [31:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while ((32'(bus.control_fsm_state) !== st) && (n < budget)) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.control_fsm_state), st);
    endtask

    // One healthy test of channel ch; test_window is rewritten to win_after
    // right after COUNTING starts, which must not affect the current window.
    task automatic run_ch(input int ch, input int exp_len, input logic [15:0] win_after);
        int len;
        int bad;
        wait_state(S_ACK, 8, "run_enter_ack");
        check("run_ch_sel", 32'(bus.ch_sel), 32'(ch));
        check("run_reset_oh", 32'(bus.reset_cut_count), 32'(oh(ch)));
        ticks(2);
        bus.reset_ack = oh(ch);
        tick();
        bus.reset_ack   = '0;
        bus.test_window = win_after;
        check("run_counting", 32'(bus.control_fsm_state), S_COUNT);
        check("run_reset_off", 32'(bus.reset_cut_count), 32'h0);
        len = 0;
        bad = 0;
        while ((32'(bus.control_fsm_state) === S_COUNT) && (len < 400)) begin
            if (bus.en_cut_count !== oh(ch)) bad++;
            len++;
            tick();
        end
        check("count_len", 32'(len), 32'(exp_len));
        check("count_onehot", 32'(bad), 32'h0);
        check("flag_gen_state", 32'(bus.control_fsm_state), S_FLAG);
        check("en_drop", 32'(bus.en_cut_count), 32'h0);
        tick();
        bus.cut_count_available = oh(ch);
        tick();
        bus.cut_count_available = '0;
        check("flag_state", 32'(bus.control_fsm_state), S_NEXT);
        check("flag_pulse", 32'(bus.en_flag_gen), 32'h1);
        check("flag_not_stopped", 32'(bus.cut_clock_stopped), 32'h0);
        check("flag_ch", 32'(bus.ch_sel), 32'(ch));
        tick();
        check("flag_end", 32'(bus.en_flag_gen), 32'h0);
        check("next_ch", 32'(bus.ch_sel), 32'((ch + 1) % N_CH));
        check("back_reset", 32'(bus.control_fsm_state), S_RESET);
    endtask

    // Channel ch never acks (other channels do, and must be ignored).
    task automatic ack_timeout(input int ch, input logic stopped);
        int p0;
        wait_state(S_ACK, 8, "to_enter_ack");
        check("to_ch_sel", 32'(bus.ch_sel), 32'(ch));
        bus.reset_ack = ~oh(ch);
        p0 = flag_pulses;
        ticks(ACK_TIMEOUT - 1);
        check("to_hold", 32'(bus.control_fsm_state), S_ACK);
        tick();
        bus.reset_ack = '0;
        if (stopped) begin
            check("stop_state", 32'(bus.control_fsm_state), S_STOPPED);
            check("stop_flag", 32'(bus.en_flag_gen), 32'h1);
            check("stop_qual", 32'(bus.cut_clock_stopped), 32'h1);
            check("stop_ch", 32'(bus.ch_sel), 32'(ch));
        end else begin
            check("retry_state", 32'(bus.control_fsm_state), S_RESET);
            check("retry_ch", 32'(bus.ch_sel), 32'(ch));
            check("retry_no_flag", 32'(flag_pulses - p0), 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable              = 1'b0;
        bus.test_window         = 16'd100;
        bus.reset_ack           = '0;
        bus.cut_count_available = '0;
        bus.flag_int_error      = 1'b0;

        // Reset values.
        ticks(2);
        check("rst_state", 32'(bus.control_fsm_state), S_RESET);
        check("rst_ch_sel", 32'(bus.ch_sel), 32'h0);
        check("rst_reset_cut", 32'(bus.reset_cut_count), 32'h0);
        check("rst_en_cut", 32'(bus.en_cut_count), 32'h0);
        check("rst_flag", 32'(bus.en_flag_gen), 32'h0);
        check("rst_sticky", 32'(bus.stopped_sticky), 32'h0);
        rst = 1'b0;

        // enable low: hold in RESET with the channel-0 counter in reset.
        tick();
        check("idle_reset_cut", 32'(bus.reset_cut_count), 32'h1);
        ticks(5);
        check("idle_state", 32'(bus.control_fsm_state), S_RESET);
        check("idle_reset_hold", 32'(bus.reset_cut_count), 32'h1);

        // Round 1: healthy channels 0..3, window 100.
        bus.enable = 1'b1;
        tick();
        run_ch(0, 100, 16'd100);
        run_ch(1, 100, 16'd100);
        run_ch(2, 100, 16'd100);
        run_ch(3, 100, 16'd0);
        check("round1_pulses", 32'(flag_pulses), 32'd4);

        // Round 2: zero window, single ack failure on ch1, stuck ch2, priorities on ch3.
        run_ch(0, 1, 16'd100);
        ack_timeout(1, 1'b0);
        run_ch(1, 100, 16'd100);
        ack_timeout(2, 1'b0);
        ack_timeout(2, 1'b1);
        check("sticky_ch2", 32'(bus.stopped_sticky), 32'h4);
        tick();
        check("stop_next_state", 32'(bus.control_fsm_state), S_NEXT);
        check("stop_pulse_end", 32'(bus.en_flag_gen), 32'h0);
        check("stop_qual_end", 32'(bus.cut_clock_stopped), 32'h0);
        check("stop_next_ch_hold", 32'(bus.ch_sel), 32'h2);
        tick();
        check("after_stop_ch", 32'(bus.ch_sel), 32'h3);

        wait_state(S_ACK, 8, "prio_enter_ack");
        ticks(ACK_TIMEOUT - 1);
        bus.reset_ack = oh(3);
        tick();
        bus.reset_ack = '0;
        check("prio_ack_over_tc", 32'(bus.control_fsm_state), S_COUNT);
        wait_state(S_FLAG, 200, "prio_enter_flag");
        ticks(ACK_TIMEOUT - 1);
        check("prio_flag_hold", 32'(bus.control_fsm_state), S_FLAG);
        bus.cut_count_available = oh(3);
        tick();
        bus.cut_count_available = '0;
        check("prio_avail_state", 32'(bus.control_fsm_state), S_NEXT);
        check("prio_avail_flag", 32'(bus.en_flag_gen), 32'h1);
        check("prio_avail_qual", 32'(bus.cut_clock_stopped), 32'h0);
        tick();
        check("round2_wrap", 32'(bus.ch_sel), 32'h0);

        // Round 3: ch1 fail counter was cleared, stopped ch2 is re-tested.
        run_ch(0, 100, 16'd100);
        ack_timeout(1, 1'b0);
        run_ch(1, 100, 16'd100);
        run_ch(2, 100, 16'd100);
        check("sticky_persist", 32'(bus.stopped_sticky), 32'h4);

        // Internal error during COUNTING on ch3.
        wait_state(S_ACK, 8, "err_enter_ack");
        bus.reset_ack = oh(3);
        tick();
        bus.reset_ack = '0;
        check("err_counting", 32'(bus.control_fsm_state), S_COUNT);
        ticks(10);
        bus.flag_int_error = 1'b1;
        tick();
        bus.flag_int_error = 1'b0;
        check("err_state", 32'(bus.control_fsm_state), S_ERR);
        check("err_en_cut", 32'(bus.en_cut_count), 32'h0);
        check("err_reset_cut", 32'(bus.reset_cut_count), 32'h0);
        check("err_flag", 32'(bus.en_flag_gen), 32'h0);
        ticks(1000);
        check("err_hold_state", 32'(bus.control_fsm_state), S_ERR);
        check("err_hold_en", 32'(bus.en_cut_count), 32'h0);
        check("err_hold_reset", 32'(bus.reset_cut_count), 32'h0);
        check("err_sticky_kept", 32'(bus.stopped_sticky), 32'h4);

        // Asynchronous reset between edges clears everything immediately.
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_state", 32'(bus.control_fsm_state), S_RESET);
        check("arst_ch_sel", 32'(bus.ch_sel), 32'h0);
        check("arst_sticky", 32'(bus.stopped_sticky), 32'h0);
        check("arst_reset_cut", 32'(bus.reset_cut_count), 32'h0);
        check("arst_en_cut", 32'(bus.en_cut_count), 32'h0);
        check("arst_qual", 32'(bus.cut_clock_stopped), 32'h0);
        #2;
        rst = 1'b0;
        tick();
        check("post_rst_state", 32'(bus.control_fsm_state), S_RESET);
        check("post_rst_reset_cut", 32'(bus.reset_cut_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
